vote_session_ctrl: RTL and testbench
====================================

VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: consecutive cycles a single button must be held to count as a vote (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: armed-ballot expiry in cycles (legal range 1..65535).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mode  input  1  0 = voting, 1 = results display.
REQ-006 SHALL have port arm  input  1  officer pulse enabling one ballot.
REQ-007 SHALL have ports button1..button4  input  1 each  candidate buttons, synchronous to clock.
REQ-008 SHALL have port vote_valid  output  1  one-cycle strobe to the counting datapath.
REQ-009 SHALL have port vote_sel  output  2  candidate index 0..3 (button1..button4); meaningful only while vote_valid=1.
REQ-010 SHALL have port ballot_armed  output  1  high in ARMED or DEBOUNCE.
REQ-011 SHALL have port multi_press  output  1  one-cycle strobe when more than one button is sampled high in ARMED/DEBOUNCE.
REQ-012 SHALL have port timeout  output  1  one-cycle expiry strobe.
REQ-013 SHALL have port disp_en  output  1  high in RESULTS.
REQ-014 SHALL have port disp_sel  output  2  candidate selected for display.

Function
REQ-015 SHALL implement states IDLE, ARMED, DEBOUNCE, COMMIT, RELEASE_WAIT, RESULTS; all outputs registered.
REQ-016 IDLE: arm=1 and mode=0 -> ARMED; arm is ignored in every other state.
REQ-017 ARMED: exactly one button high -> DEBOUNCE with hold_cnt=1 and the index latched; zero buttons -> stay.
REQ-018 DEBOUNCE: the same single button high -> hold_cnt+1; when hold_cnt reaches HOLD_CYCLES -> COMMIT.
REQ-019 DEBOUNCE: release or a different single button -> ARMED with hold_cnt=0; the ballot stays armed.
REQ-020 Two or more buttons high in ARMED/DEBOUNCE -> multi_press pulse, go to/stay ARMED, hold_cnt=0; no vote.
REQ-021 COMMIT lasts exactly one cycle: vote_valid=1, vote_sel=latched index; then -> RELEASE_WAIT.
REQ-022 First vote_valid cycle follows the HOLD_CYCLES-th consecutive sampling edge with the same button high.
REQ-023 RELEASE_WAIT: all buttons low -> IDLE; a held button never produces a second vote.
REQ-024 mode=1 in any state except COMMIT -> RESULTS next cycle; any armed ballot is discarded without a vote.
REQ-025 mode=1 during COMMIT: the vote completes, then -> RESULTS.
REQ-026 RESULTS: disp_en=1; a single button high loads disp_sel; multiple buttons ignored; mode=0 -> IDLE.
REQ-027 disp_sel SHALL hold its value outside RESULTS.
REQ-028 vote_valid SHALL assert at most once per arm pulse.

Reset
REQ-029 reset=1 SHALL force IDLE and hold_cnt=0, timer=0, vote_sel=0, disp_sel=0, with all strobes/flags 0, immediately and independent of clock.
REQ-030 Reset asserted mid-DEBOUNCE or mid-COMMIT SHALL discard the ballot; vote_valid=0 with no glitch after release.

Configuration
REQ-031 Macro VOTE_TIMEOUT_EN defined: a 16-bit timer clears on entry to ARMED from IDLE and counts in ARMED/DEBOUNCE.
REQ-032 With VOTE_TIMEOUT_EN, the timer reaching TIMEOUT_CYCLES -> IDLE plus a one-cycle timeout pulse; if that same cycle would enter COMMIT, COMMIT wins.
REQ-033 Macro VOTE_TIMEOUT_EN undefined: no timer logic, timeout tied 0, ballot stays armed indefinitely.

Verification
REQ-034 Reset, arm, button2 held 6 cycles (HOLD_CYCLES=4) -> one vote_valid, vote_sel=1, then IDLE after release.
REQ-035 Armed, button2+button3 together -> multi_press pulse, no vote_valid; later button3 alone for 4 cycles -> vote_sel=2.
REQ-036 Armed, button1 held 2 cycles, released, then held 4 -> exactly one vote; second arm without release stays in RELEASE_WAIT.
REQ-037 mode=1 while armed, then button3 -> disp_en=1, disp_sel=2, no vote; mode=0 -> IDLE, arm required again.
REQ-038 VOTE_TIMEOUT_EN, TIMEOUT_CYCLES=20, arm with no press -> timeout at cycle 20, ballot_armed=0; undefined build -> still armed at 100.
REQ-039 reset pulse during DEBOUNCE -> all outputs 0 asynchronously, no vote after deassertion.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// Single-ballot voting controller: arm, debounce one candidate button, strobe one vote, results display.
// Optional ballot expiry timer is compiled in when VOTE_TIMEOUT_EN is defined.
module vote_session_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       arm,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic       vote_valid,
    output logic [1:0] vote_sel,
    output logic       ballot_armed,
    output logic       multi_press,
    output logic       timeout,
    output logic       disp_en,
    output logic [1:0] disp_sel
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DEBOUNCE,
        S_COMMIT,
        S_RELEASE_WAIT,
        S_RESULTS
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] vote_sel_q, vote_sel_d;
    logic [1:0] disp_sel_q, disp_sel_d;
    logic       multi_q, multi_d;
    logic       timeout_q, timeout_d;
    logic       vote_valid_q, armed_q, disp_en_q;

    logic [3:0] btn;
    logic       single;
    logic       multi;
    logic [1:0] btn_idx;
    logic       expire;

    assign btn = {button4, button3, button2, button1};

    always_comb begin
        single  = 1'b1;
        btn_idx = 2'd0;
        case (btn)
            4'b0001: btn_idx = 2'd0;
            4'b0010: btn_idx = 2'd1;
            4'b0100: btn_idx = 2'd2;
            4'b1000: btn_idx = 2'd3;
            default: single = 1'b0;
        endcase
    end

    assign multi = (btn != 4'b0000) && !single;

`ifdef VOTE_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;

    // Holding the timer at zero while idle gives a cleared count on every arm.
    always_comb begin
        timer_d = timer_q;
        expire  = 1'b0;
        if (state_q == S_IDLE) begin
            timer_d = '0;
        end else if (state_q == S_ARMED || state_q == S_DEBOUNCE) begin
            timer_d = timer_q + 16'd1;
            expire  = (timer_d == 16'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        idx_d      = idx_q;
        vote_sel_d = vote_sel_q;
        disp_sel_d = disp_sel_q;
        multi_d    = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mode) begin
                    state_d = S_RESULTS;
                end else if (arm) begin
                    state_d    = S_ARMED;
                    hold_cnt_d = '0;
                end
            end
            S_ARMED, S_DEBOUNCE: begin
                multi_d = multi;
                if (mode) begin
                    state_d    = S_RESULTS;
                    hold_cnt_d = '0;
                end else begin
                    if (!single) begin
                        state_d    = S_ARMED;
                        hold_cnt_d = '0;
                    end else if (state_q == S_ARMED) begin
                        state_d    = S_DEBOUNCE;
                        hold_cnt_d = 8'd1;
                        idx_d      = btn_idx;
                    end else if (btn_idx == idx_q) begin
                        if (hold_cnt_q == 8'(HOLD_CYCLES - 1)) begin
                            state_d    = S_COMMIT;
                            hold_cnt_d = '0;
                            vote_sel_d = idx_q;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d    = S_ARMED;
                        hold_cnt_d = '0;
                    end
                    // A vote completing on the expiry edge still counts.
                    if (expire && state_d != S_COMMIT) begin
                        state_d    = S_IDLE;
                        hold_cnt_d = '0;
                        timeout_d  = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                state_d = mode ? S_RESULTS : S_RELEASE_WAIT;
            end
            S_RELEASE_WAIT: begin
                if (mode) begin
                    state_d = S_RESULTS;
                end else if (btn == 4'b0000) begin
                    state_d = S_IDLE;
                end
            end
            S_RESULTS: begin
                if (single) begin
                    disp_sel_d = btn_idx;
                end
                if (!mode) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            idx_q        <= '0;
            vote_sel_q   <= '0;
            disp_sel_q   <= '0;
            multi_q      <= 1'b0;
            timeout_q    <= 1'b0;
            vote_valid_q <= 1'b0;
            armed_q      <= 1'b0;
            disp_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            idx_q        <= idx_d;
            vote_sel_q   <= vote_sel_d;
            disp_sel_q   <= disp_sel_d;
            multi_q      <= multi_d;
            timeout_q    <= timeout_d;
            vote_valid_q <= (state_d == S_COMMIT);
            armed_q      <= (state_d == S_ARMED) || (state_d == S_DEBOUNCE);
            disp_en_q    <= (state_d == S_RESULTS);
        end
    end

    assign vote_valid   = vote_valid_q;
    assign vote_sel     = vote_sel_q;
    assign ballot_armed = armed_q;
    assign multi_press  = multi_q;
    assign timeout      = timeout_q;
    assign disp_en      = disp_en_q;
    assign disp_sel     = disp_sel_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: ballot-level reference model checked every cycle, plus literal checks.
module tb_vote_session_ctrl;

    localparam int HOLD = 4;
    localparam int TO   = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode  = 1'b0;
    logic       arm   = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic       vote_valid, ballot_armed, multi_press, timeout, disp_en;
    logic [1:0] vote_sel, disp_sel;

    vote_session_ctrl #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .mode(mode), .arm(arm),
        .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
        .vote_valid(vote_valid), .vote_sel(vote_sel), .ballot_armed(ballot_armed),
        .multi_press(multi_press), .timeout(timeout), .disp_en(disp_en), .disp_sel(disp_sel)
    );

    initial forever #5 clock = ~clock;

    // Ballot-level model: an open ballot, a run length of one candidate, a release wait, a display flag.
    typedef struct packed {
        logic       open;
        logic       waitrel;
        logic       results;
        int         run;
        int         cand;
        int         timer;
        logic       e_vv;
        logic [1:0] e_sel;
        logic       e_armed;
        logic       e_multi;
        logic       e_to;
        logic       e_den;
        logic [1:0] e_dsel;
    } model_t;

    model_t m = '0;

    function automatic model_t next_model(input model_t s, input logic md, input logic ar, input logic [3:0] b);
        model_t n;
        int nb;
        int who;
        n = s;
        nb = $countones(b);
        who = 0;
        for (int i = 0; i < 4; i++) if (b[i]) who = i;
        n.e_multi = 1'b0;
        n.e_to    = 1'b0;
        n.e_vv    = 1'b0;
        if (s.e_vv) begin
            if (md) n.results = 1'b1;
            else    n.waitrel = 1'b1;
        end else if (s.results) begin
            if (nb == 1) n.e_dsel = 2'(who);
            if (!md) n.results = 1'b0;
        end else if (md) begin
            if (s.open && nb >= 2) n.e_multi = 1'b1;
            n.results = 1'b1;
            n.open    = 1'b0;
            n.waitrel = 1'b0;
            n.run     = 0;
        end else if (s.waitrel) begin
            if (nb == 0) n.waitrel = 1'b0;
        end else if (s.open) begin
            n.timer = s.timer + 1;
            if (nb >= 2) begin
                n.e_multi = 1'b1;
                n.run = 0;
            end else if (nb == 1 && s.run > 0 && who == s.cand) begin
                n.run = s.run + 1;
            end else if (nb == 1 && s.run == 0) begin
                n.run  = 1;
                n.cand = who;
            end else begin
                n.run = 0;
            end
            if (n.run == HOLD) begin
                n.e_vv  = 1'b1;
                n.e_sel = 2'(n.cand);
                n.open  = 1'b0;
                n.run   = 0;
            end
`ifdef VOTE_TIMEOUT_EN
            else if (n.timer == TO) begin
                n.e_to = 1'b1;
                n.open = 1'b0;
                n.run  = 0;
            end
`endif
        end else if (ar) begin
            n.open  = 1'b1;
            n.timer = 0;
            n.run   = 0;
        end
        n.e_armed = n.open;
        n.e_den   = n.results;
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m <= '0;
        else       m <= next_model(m, mode, arm, btn);
    end

    int checks = 0;
    int errors = 0;
    int votes = 0;
    int multis = 0;
    int timeouts = 0;
    int last_sel = -1;
    int v0, mu0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("vote_valid", int'(vote_valid), int'(m.e_vv));
        if (m.e_vv) chk("vote_sel", int'(vote_sel), int'(m.e_sel));
        chk("ballot_armed", int'(ballot_armed), int'(m.e_armed));
        chk("multi_press", int'(multi_press), int'(m.e_multi));
        chk("timeout", int'(timeout), int'(m.e_to));
        chk("disp_en", int'(disp_en), int'(m.e_den));
        chk("disp_sel", int'(disp_sel), int'(m.e_dsel));
        if (vote_valid) begin
            votes++;
            last_sel = int'(vote_sel);
        end
        if (multi_press) multis++;
        if (timeout) timeouts++;
    endtask

    task automatic cyc(input logic md, input logic ar, input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mode = md;
            arm  = ar;
            btn  = b;
            @(posedge clock);
            @(negedge clock);
            compare_all();
        end
    endtask

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 4'b0000, 2);
        chk("rst_vote_valid", int'(vote_valid), 0);
        chk("rst_armed", int'(ballot_armed), 0);
        chk("rst_disp_en", int'(disp_en), 0);
        reset = 1'b0;

        // button2 held 6 cycles: one vote for index 1, idle after release
        v0 = votes;
        cyc(1'b0, 1'b1, 4'b0000, 1);
        chk("s1_armed", int'(ballot_armed), 1);
        cyc(1'b0, 1'b0, 4'b0010, 3);
        chk("s1_no_vote_yet", votes - v0, 0);
        cyc(1'b0, 1'b0, 4'b0010, 1);
        chk("s1_vote_on_4th", int'(vote_valid), 1);
        cyc(1'b0, 1'b0, 4'b0010, 2);
        cyc(1'b0, 1'b0, 4'b0000, 2);
        chk("s1_votes", votes - v0, 1);
        chk("s1_sel", last_sel, 1);
        chk("s1_idle_armed", int'(ballot_armed), 0);

        // button2+button3 together, then button3 alone
        v0 = votes; mu0 = multis;
        cyc(1'b0, 1'b1, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b0110, 1);
        chk("s2_multi", int'(multi_press), 1);
        cyc(1'b0, 1'b0, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b0100, 4);
        cyc(1'b0, 1'b0, 4'b0000, 2);
        chk("s2_votes", votes - v0, 1);
        chk("s2_sel", last_sel, 2);
        chk("s2_multis", multis - mu0, 1);

        // button1 interrupted, then held; re-arm during release wait is ignored
        v0 = votes;
        cyc(1'b0, 1'b1, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b0001, 2);
        cyc(1'b0, 1'b0, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b0001, 4);
        cyc(1'b0, 1'b0, 4'b0001, 1);
        cyc(1'b0, 1'b1, 4'b0001, 1);
        cyc(1'b0, 1'b0, 4'b0001, 6);
        chk("s3_votes", votes - v0, 1);
        chk("s3_sel", last_sel, 0);
        chk("s3_rw_armed", int'(ballot_armed), 0);
        cyc(1'b0, 1'b0, 4'b0000, 2);

        // results mode discards armed ballot
        v0 = votes;
        cyc(1'b0, 1'b1, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b0000, 1);
        cyc(1'b1, 1'b0, 4'b0000, 1);
        cyc(1'b1, 1'b0, 4'b0100, 1);
        cyc(1'b1, 1'b0, 4'b0011, 1);
        chk("s4_disp_en", int'(disp_en), 1);
        chk("s4_disp_sel", int'(disp_sel), 2);
        cyc(1'b0, 1'b0, 4'b0000, 1);
        chk("s4_disp_off", int'(disp_en), 0);
        chk("s4_disp_hold", int'(disp_sel), 2);
        cyc(1'b0, 1'b0, 4'b0100, 5);
        chk("s4_votes", votes - v0, 0);
        chk("s4_not_armed", int'(ballot_armed), 0);
        cyc(1'b0, 1'b0, 4'b0000, 1);

        // switching to a different single button restarts the count
        v0 = votes;
        cyc(1'b0, 1'b1, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b0001, 2);
        cyc(1'b0, 1'b0, 4'b0010, 4);
        chk("s5_no_vote_yet", votes - v0, 0);
        cyc(1'b0, 1'b0, 4'b0010, 1);
        chk("s5_votes", votes - v0, 1);
        chk("s5_sel", last_sel, 1);
        cyc(1'b0, 1'b0, 4'b0000, 2);

        // mode raised while the vote is being strobed: vote completes, then display
        v0 = votes;
        cyc(1'b0, 1'b1, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b1000, 4);
        cyc(1'b1, 1'b0, 4'b0000, 1);
        chk("s6_votes", votes - v0, 1);
        chk("s6_sel", last_sel, 3);
        chk("s6_disp_en", int'(disp_en), 1);
        cyc(1'b0, 1'b0, 4'b0000, 1);

        // asynchronous reset during debounce
        v0 = votes;
        cyc(1'b0, 1'b1, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b1000, 2);
        chk("s7_armed_before", int'(ballot_armed), 1);
        chk("s7_dsel_before", int'(disp_sel), 2);
        #2 reset = 1'b1;
        #1;
        chk("s7_rst_armed", int'(ballot_armed), 0);
        chk("s7_rst_vv", int'(vote_valid), 0);
        chk("s7_rst_dsel", int'(disp_sel), 0);
        chk("s7_rst_den", int'(disp_en), 0);
        cyc(1'b0, 1'b0, 4'b1000, 1);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 4'b1000, 5);
        chk("s7_votes", votes - v0, 0);
        cyc(1'b0, 1'b0, 4'b0000, 1);

        // asynchronous reset while the vote strobe is high
        v0 = votes;
        cyc(1'b0, 1'b1, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b1000, 3);
        btn = 4'b1000;
        @(posedge clock);
        #1;
        chk("s8_commit_vv", int'(vote_valid), 1);
        reset = 1'b1;
        #1;
        chk("s8_rst_vv", int'(vote_valid), 0);
        chk("s8_rst_sel", int'(vote_sel), 0);
        @(negedge clock);
        compare_all();
        cyc(1'b0, 1'b0, 4'b1000, 1);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 4'b1000, 3);
        chk("s8_votes", votes - v0, 0);
        cyc(1'b0, 1'b0, 4'b0000, 1);

        // armed ballot with no press: expiry or indefinite hold
        cyc(1'b0, 1'b1, 4'b0000, 1);
        cyc(1'b0, 1'b0, 4'b0000, TO - 1);
`ifdef VOTE_TIMEOUT_EN
        chk("s9_no_to_yet", int'(timeout), 0);
        chk("s9_armed_19", int'(ballot_armed), 1);
        cyc(1'b0, 1'b0, 4'b0000, 1);
        chk("s9_timeout", int'(timeout), 1);
        chk("s9_disarmed", int'(ballot_armed), 0);
        cyc(1'b0, 1'b0, 4'b0000, 2);
        chk("s9_timeouts", timeouts, 1);
`else
        cyc(1'b0, 1'b0, 4'b0000, 100 - (TO - 1));
        chk("s9_still_armed", int'(ballot_armed), 1);
        chk("s9_timeouts", timeouts, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
